// File: rtl/ddr2_traffic_gen.sv
// ddr2_traffic_gen: writes an LFSR data pattern across a block of DDR2 words.
// It then reads the block back and checks each returned word and address
// against a second copy of the same LFSR sequence.
module ddr2_traffic_gen #(
   parameter int          NUM_WORDS  = 64,
   parameter logic [24:0] BASE_ADDR  = 25'h0000000,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter logic [6:0]  FILL_LIMIT = 7'd56,
   parameter int          TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ready,
   input  logic        notfull,
   input  logic [6:0]  fillcount,
   output logic [2:0]  cmd,
   output logic [1:0]  sz,
   output logic [2:0]  op,
   output logic [15:0] din,
   output logic [24:0] addr,
   output logic        fetching,
   input  logic [15:0] dout,
   input  logic [24:0] raddr,
   input  logic        validout,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] err_count,
   output logic [24:0] first_err_addr
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_RDY = 3'd1;
   localparam logic [2:0] ST_WRITE    = 3'd2;
   localparam logic [2:0] ST_DRAIN    = 3'd3;
   localparam logic [2:0] ST_READ     = 3'd4;
   localparam logic [2:0] ST_COLLECT  = 3'd5;
   localparam logic [2:0] ST_FINISH   = 3'd6;

   localparam logic [2:0] CMD_NOP = 3'b000;
   localparam logic [2:0] CMD_SCR = 3'b001;
   localparam logic [2:0] CMD_SCW = 3'b010;

   localparam int              IDLE_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [15:0]     LAST_IDX  = 16'(NUM_WORDS - 1);
   localparam logic [16:0]     WORDS_17  = 17'(NUM_WORDS);

   logic [2:0]        state;
   logic [15:0]       cmd_idx;
   logic [15:0]       rsp_idx;
   logic [15:0]       wr_lfsr;
   logic [15:0]       chk_lfsr;
   logic [IDLE_W-1:0] idle_cnt;
   logic              drain_zero;
   logic              done_q;
   logic              pass_q;

   logic              start_run;
   logic              can_issue;
   logic              issue_wr;
   logic              issue_rd;
   logic              check_active;
   logic              check_en;
   logic              mismatch;
   logic              last_cmd;
   logic              timeout_hit;
   logic              rsp_complete;
   logic [16:0]       rsp_total;
   logic [24:0]       cmd_addr;
   logic [24:0]       exp_raddr;

   // Fibonacci LFSR step: taps 16,14,13,11, shifting left with feedback into bit 0
   function automatic logic [15:0] lfsr_next(input logic [15:0] value);
      return {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
   endfunction

   // Issue qualification, address generation and read-response comparison
   always_comb begin
      start_run    = (state == ST_IDLE) && start;
      can_issue    = notfull && (fillcount < FILL_LIMIT);
      issue_wr     = (state == ST_WRITE) && can_issue;
      issue_rd     = (state == ST_READ) && can_issue;
      check_active = (state == ST_READ) || (state == ST_COLLECT);
      check_en     = check_active && validout;
      cmd_addr     = BASE_ADDR + {9'd0, cmd_idx};
      exp_raddr    = BASE_ADDR + {9'd0, rsp_idx};
      mismatch     = check_en && ((dout != chk_lfsr) || (raddr != exp_raddr));
      last_cmd     = (cmd_idx == LAST_IDX);
      timeout_hit  = check_active && !validout && (idle_cnt == IDLE_LAST);
      rsp_total    = {1'b0, rsp_idx} + {16'd0, check_en};
      rsp_complete = (rsp_total >= WORDS_17);
   end

   // Controller-facing outputs and run status; address and data read as zero outside the issue phases
   always_comb begin
      cmd      = CMD_NOP;
      if (issue_wr) begin
         cmd = CMD_SCW;
      end else if (issue_rd) begin
         cmd = CMD_SCR;
      end
      sz       = 2'b00;
      op       = 3'b000;
      addr     = ((state == ST_WRITE) || (state == ST_READ)) ? cmd_addr : 25'd0;
      din      = (state == ST_WRITE) ? wr_lfsr : 16'd0;
      fetching = check_active;
      busy     = (state != ST_IDLE) && (state != ST_FINISH);
      done     = done_q || (state == ST_FINISH);
      pass     = (state == ST_FINISH) ? ((err_count == 16'd0) && !timeout) : pass_q;
   end

   // Main sequencer: write pass, drain wait, read pass, then wait for all responses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cmd_idx    <= 16'd0;
         wr_lfsr    <= SEED;
         drain_zero <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_WAIT_RDY;
                  cmd_idx <= 16'd0;
                  wr_lfsr <= SEED;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end
            end
            ST_WAIT_RDY: begin
               if (ready) begin
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (issue_wr) begin
                  wr_lfsr <= lfsr_next(wr_lfsr);
                  if (last_cmd) begin
                     cmd_idx    <= 16'd0;
                     drain_zero <= 1'b0;
                     state      <= ST_DRAIN;
                  end else begin
                     cmd_idx <= cmd_idx + 16'd1;
                  end
               end
            end
            ST_DRAIN: begin
               drain_zero <= (fillcount == 7'd0);
               if ((fillcount == 7'd0) && drain_zero) begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               if (timeout_hit) begin
                  state <= ST_FINISH;
               end else if (issue_rd) begin
                  if (last_cmd) begin
                     state <= ST_COLLECT;
                  end else begin
                     cmd_idx <= cmd_idx + 16'd1;
                  end
               end
            end
            ST_COLLECT: begin
               if (timeout_hit || rsp_complete) begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               done_q <= 1'b1;
               pass_q <= (err_count == 16'd0) && !timeout;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read checker: tracks the expected response stream, counts mismatches and watches for stalls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_idx        <= 16'd0;
         chk_lfsr       <= SEED;
         idle_cnt       <= '0;
         timeout        <= 1'b0;
         err_count      <= 16'd0;
         first_err_addr <= 25'd0;
      end else if (start_run) begin
         rsp_idx        <= 16'd0;
         chk_lfsr       <= SEED;
         idle_cnt       <= '0;
         timeout        <= 1'b0;
         err_count      <= 16'd0;
         first_err_addr <= 25'd0;
      end else if (check_active) begin
         if (validout) begin
            rsp_idx  <= rsp_idx + 16'd1;
            chk_lfsr <= lfsr_next(chk_lfsr);
            idle_cnt <= '0;
            if (mismatch) begin
               if (err_count == 16'd0) begin
                  first_err_addr <= raddr;
               end
               if (err_count != 16'hFFFF) begin
                  err_count <= err_count + 16'd1;
               end
            end
         end else if (timeout_hit) begin
            timeout <= 1'b1;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

endmodule
